count_seg7_scan: RTL and testbench

- Downstream display stage for the 5-bit up/down counter.
- Consumes the live count (0..31), converts it to two BCD digits, and time-multiplexes them onto a 2-digit common-anode seven-segment display.
- A frame-aligned snapshot keeps both digits of one frame coherent while the counter changes every clock.

---
 rtl/count_seg7_pkg.sv | 27 ++
 rtl/count_seg7_scan_bcd_to_seg7.sv | 26 ++
 rtl/count_seg7_scan.sv | 86 ++++++++
 tb/tb_count_seg7_scan.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/count_seg7_pkg.sv
// count_seg7_pkg: shared constants for the two-digit seven-segment scanner
package count_seg7_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Which digit slot is currently being driven
    typedef enum logic {
        UNITS = 1'b0,
        TENS  = 1'b1
    } digit_t;

    // Anode bit positions
    localparam int AN_UNITS = 0;
    localparam int AN_TENS  = 1;

endpackage

// File: rtl/count_seg7_scan_bcd_to_seg7.sv
// bcd_to_seg7: one BCD digit to an active-high {g..a} pattern, non-decimal codes dark
module bcd_to_seg7
    import count_seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Plain decode table; 10..15 never occur from the converter but stay dark
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/count_seg7_scan.sv
// count_seg7_scan: snapshot a 0..31 count and scan it as two BCD digits onto a
// common-anode display. Define COUNT_SEG7_LEADING_ZERO_BLANK_EN to darken the
// tens slot when the tens digit is zero.
module count_seg7_scan
    import count_seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] count,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int             PW        = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  LAST      = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_BLANK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [1:0]     AN_BLANK  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [PW-1:0] presc;
    logic          tick;
    digit_t        state;
    logic [4:0]    snap;
    logic [1:0]    tens;
    logic [3:0]    units;
    logic [3:0]    digit;
    logic [6:0]    pat;
    logic          blank;
    logic [6:0]    seg_on;
    logic [1:0]    an_on;

    assign tick = presc == LAST;

    // Slot-length prescaler, wraps after REFRESH_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            presc <= '0;
        else
            presc <= tick ? '0 : presc + 1'b1;
    end

    // Digit FSM; the snapshot is taken when leaving TENS so a frame never mixes samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNITS;
            snap  <= '0;
        end else if (tick) begin
            state <= state == UNITS ? TENS : UNITS;
            if (state == TENS)
                snap <= count;
        end
    end

    assign tens  = snap >= 5'd30 ? 2'd3 : snap >= 5'd20 ? 2'd2 : snap >= 5'd10 ? 2'd1 : 2'd0;
    assign units = 4'(snap - 5'd10 * {3'b000, tens});
    assign digit = state == TENS ? {2'b00, tens} : units;

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (pat)
    );

`ifdef COUNT_SEG7_LEADING_ZERO_BLANK_EN
    assign blank = state == TENS && tens == 2'd0;
`else
    assign blank = 1'b0;
`endif

    assign seg_on = blank ? SEG_OFF : pat;
    assign an_on  = blank ? 2'b00 : state == TENS ? 2'(1 << AN_TENS) : 2'(1 << AN_UNITS);

    // Registered drive; seg and an share one edge so digits never ghost into each other
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= SEG_BLANK;
            an  <= AN_BLANK;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            an  <= AN_ACTIVE_LOW ? ~an_on : an_on;
        end
    end

endmodule

// File: tb/tb_count_seg7_scan.sv
// tb_count_seg7_scan: scoreboard bench for the scanner at REFRESH_DIV=4 and REFRESH_DIV=1
module tb_count_seg7_scan;

    localparam logic [8:0] BLANK = {2'b11, 7'h7F};
    localparam logic [6:0] LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef COUNT_SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [8:0] TZ = BLANK;
`else
    localparam logic [8:0] TZ = {2'b01, 7'h40};
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] count = 5'd0;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;

    int checks = 0;
    int errors = 0;
    int ne = 0;

    logic [1:0] mp0;
    logic       ms0, ms1;
    logic [4:0] mn0, mn1;
    logic [8:0] q0[$], q1[$];

    always #5 clk = ~clk;

    count_seg7_scan #(.REFRESH_DIV(4)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .count   (count),
        .seg     (seg0),
        .an      (an0)
    );

    count_seg7_scan #(.REFRESH_DIV(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .count   (count),
        .seg     (seg1),
        .an      (an1)
    );

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got an/seg %b/%h expected %b/%h", tag, got[8:7], got[6:0], exp[8:7], exp[6:0]);
        end
    endtask

    function automatic logic [8:0] expv(input logic st, input logic [4:0] n);
        int t = int'(n) / 10;
        int u = int'(n) % 10;
        if (!st)
            return {2'b10, LUT[u]};
`ifdef COUNT_SEG7_LEADING_ZERO_BLANK_EN
        if (t == 0)
            return BLANK;
`endif
        return {2'b01, LUT[t]};
    endfunction

    // Reference model: expected output for the next edge is queued as the edge happens
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mp0 <= 2'd0;
            ms0 <= 1'b0;
            mn0 <= 5'd0;
            ms1 <= 1'b0;
            mn1 <= 5'd0;
            q0.delete();
            q1.delete();
        end else begin
            q0.push_back(expv(ms0, mn0));
            q1.push_back(expv(ms1, mn1));
            mp0 <= mp0 == 2'd3 ? 2'd0 : mp0 + 2'd1;
            if (mp0 == 2'd3) begin
                ms0 <= ~ms0;
                if (ms0)
                    mn0 <= count;
            end
            ms1 <= ~ms1;
            if (ms1)
                mn1 <= count;
        end
    end

    // Scoreboard drain: nothing queued means reset is (or just was) in force
    always @(negedge clk) begin
        check("sb_div4", {an0, seg0}, q0.size() != 0 ? q0.pop_front() : BLANK);
        check("sb_div1", {an1, seg1}, q1.size() != 0 ? q1.pop_front() : BLANK);
    end

    task automatic upto(input int k);
        while (ne < k) begin
            @(negedge clk);
            ne++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (10) begin
            @(negedge clk);
            count = count ^ 5'h15;
        end
        check("in_reset", {an0, seg0}, BLANK);
        @(negedge clk);
        reset_n = 1'b1;
        count = 5'd23;
        ne = 0;
        upto(1);  check("post_rst_units0", {an0, seg0}, {2'b10, 7'h40});
        upto(5);  check("post_rst_tens0", {an0, seg0}, TZ);
        upto(9);  check("c23_units_first", {an0, seg0}, {2'b10, 7'h30});
        upto(12); check("c23_units_last", {an0, seg0}, {2'b10, 7'h30});
        count = 5'd17;
        upto(13); check("c23_tens_first", {an0, seg0}, {2'b01, 7'h24});
        upto(16); check("c23_tens_last", {an0, seg0}, {2'b01, 7'h24});
        upto(17); check("c17_units", {an0, seg0}, {2'b10, 7'h78});
        count = 5'd9;
        upto(21); check("c17_tens_held", {an0, seg0}, {2'b01, 7'h79});
        upto(25); check("c9_units", {an0, seg0}, {2'b10, 7'h10});
        count = 5'd31;
        upto(29); check("c9_tens", {an0, seg0}, TZ);
        upto(33); check("c31_units", {an0, seg0}, {2'b10, 7'h79});
        count = 5'd10;
        upto(37); check("c31_tens", {an0, seg0}, {2'b01, 7'h30});
        upto(41); check("c10_units", {an0, seg0}, {2'b10, 7'h40});
        count = 5'd0;
        upto(45); check("c10_tens", {an0, seg0}, {2'b01, 7'h79});
        upto(49); check("c0_units", {an0, seg0}, {2'b10, 7'h40});
        upto(54); check("c0_tens", {an0, seg0}, TZ);
        count = 5'd23;
        #2 reset_n = 1'b0;
        #1 check("async_rst_div4", {an0, seg0}, BLANK);
        check("async_rst_div1", {an1, seg1}, BLANK);
        @(negedge clk);
        reset_n = 1'b1;
        ne = 0;
        upto(1); check("rst2_units_a", {an0, seg0}, {2'b10, 7'h40});
        upto(4); check("rst2_units_d", {an0, seg0}, {2'b10, 7'h40});
        upto(5); check("rst2_tens", {an0, seg0}, TZ);
        upto(6);
        count = 5'd5;
        upto(9);  check("div1_units_a", {an1, seg1}, {2'b10, 7'h12});
        upto(10); check("div1_tens_a", {an1, seg1}, TZ);
        upto(11); check("div1_units_b", {an1, seg1}, {2'b10, 7'h12});
        upto(12); check("div1_tens_b", {an1, seg1}, TZ);
        upto(14);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
